sram_port_ctrl: RTL and testbench

- Front-end controller that sits directly upstream of the 2-bit x 16-word single-port RW SRAM macro.
- Turns a valid/ready request stream into the macro's csb0/web0/addr0/din0 pin sequence and captures dout0 into a response stream.
- After reset it runs an init sweep that writes INIT_VALUE to every word, so downstream never reads X.
- Sustains one request per cycle with fixed read latency.

---
 rtl/sram_port_ctrl.sv | 119 +++++++++++
 tb/tb_sram_port_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Front-end controller for a single-port RW SRAM macro: an init sweep after reset, then one
// request per cycle with registered macro pins and a fixed two-cycle read response latency.
module sram_port_ctrl #(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] SWEEP_ONE = (ADDR_WIDTH + 1)'(1);

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH:0]     cnt_q,      cnt_d;
    logic                    csb_q,      csb_d;
    logic                    web_q,      web_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   din_q,      din_d;
    logic [1:0]              rdPend_q,   rdPend_d;
    logic                    rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0]   rspData_q,  rspData_d;

    // The sweep counter carries one extra bit so the cycle after the last init write
    // can be recognised and spent moving to RUN with the macro deselected.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        addr_d     = addr_q;
        din_d      = din_q;
        rdPend_d   = {rdPend_q[0], 1'b0};
        rspValid_d = rdPend_q[1];
        rspData_d  = rdPend_q[1] ? dout0 : rspData_q;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == SWEEP_END) begin
                    state_d = ST_RUN;
                end else begin
                    csb_d  = 1'b0;
                    web_d  = 1'b0;
                    addr_d = cnt_q[ADDR_WIDTH-1:0];
                    din_d  = INIT_VALUE;
                    cnt_d  = cnt_q + SWEEP_ONE;
                end
            end
            ST_RUN: begin
                if (req_valid) begin
                    csb_d       = 1'b0;
                    web_d       = ~req_we;
                    addr_d      = req_addr;
                    rdPend_d[0] = ~req_we;
                    if (req_we) begin
                        din_d = req_wdata;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            rdPend_q   <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rdPend_q   <= rdPend_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
        end
    end

    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign csb0      = csb_q;
    assign web0      = web_q;
    assign addr0     = addr_q;
    assign din0      = din_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspData_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: a behavioural SRAM macro, a shadow memory and a response
// scoreboard checked for data and exact two-cycle latency.
module tb_sram_port_ctrl;

    logic       clk0;
    logic       rst0_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_rdata;
    logic       init_done;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [1:0] din0;
    logic [1:0] dout0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1:0] shadow [16];
    logic [1:0] expQ [$];
    int         accQ [$];

    sram_port_ctrl #(
        .DATA_WIDTH(2),
        .ADDR_WIDTH(4),
        .INIT_VALUE(2'b00)
    ) dut (
        .clk0      (clk0),
        .rst0_n    (rst0_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    // Behavioural macro: pins sampled on the rising edge, access performed on the falling edge.
    logic [1:0] mem [16];
    logic       mCsb = 1'b1;
    logic       mWeb = 1'b1;
    logic [3:0] mAddr = '0;
    logic [1:0] mDin = '0;

    always @(posedge clk0) begin
        mCsb  <= csb0;
        mWeb  <= web0;
        mAddr <= addr0;
        mDin  <= din0;
    end

    always @(negedge clk0) begin
        if (mCsb == 1'b0) begin
            if (mWeb == 1'b0) mem[mAddr] <= mDin;
            else              dout0      <= mem[mAddr];
        end
    end

    always @(negedge clk0) begin
        if (rsp_valid !== 1'b0) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_rsp: rsp_valid=%b rdata=%0d at cycle %0d, required no response",
                         rsp_valid, rsp_rdata, cyc);
            end else begin
                logic [1:0] e;
                int         a;
                e = expQ.pop_front();
                a = accQ.pop_front();
                if (rsp_rdata !== e) begin
                    bad++;
                    $display("[TB] FAIL rsp_data: got %0d, required %0d", rsp_rdata, e);
                end
                total++;
                if (cyc !== a + 2) begin
                    bad++;
                    $display("[TB] FAIL rsp_latency: response at cycle %0d, required %0d", cyc, a + 2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one request in the current cycle and record what the macro should return.
    task automatic applyStimulus(input logic we, input logic [3:0] a, input logic [1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (we) begin
            shadow[a] = d;
        end else begin
            expQ.push_back(shadow[a]);
            accQ.push_back(cyc + 1);
        end
    endtask

    task automatic clearShadow();
        for (int i = 0; i < 16; i++) shadow[i] = 2'b00;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 10) begin
            @(negedge clk0);
            n++;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_%s: %0d responses outstanding, required 0", tag, expQ.size());
            expQ.delete();
            accQ.delete();
        end
        repeat (3) @(negedge clk0);
    endtask

    task automatic test_reset();
        rst0_n = 1'b0;
        repeat (2) @(negedge clk0);
        total += 8;
        if (csb0 !== 1'b1)      begin bad++; $display("[TB] FAIL reset_csb0: got %b, required 1", csb0); end
        if (web0 !== 1'b1)      begin bad++; $display("[TB] FAIL reset_web0: got %b, required 1", web0); end
        if (addr0 !== 4'd0)     begin bad++; $display("[TB] FAIL reset_addr0: got %0d, required 0", addr0); end
        if (din0 !== 2'd0)      begin bad++; $display("[TB] FAIL reset_din0: got %0d, required 0", din0); end
        if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_rdata !== 2'd0) begin bad++; $display("[TB] FAIL reset_rsp_rdata: got %0d, required 0", rsp_rdata); end
        if (init_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_init_done: got %b, required 0", init_done); end
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready: got %b, required 0", req_ready); end
    endtask

    // Releases reset and follows the sweep; req_valid is held high to show it is ignored.
    task automatic test_init_sweep();
        @(negedge clk0);
        rst0_n    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 2'b11;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk0);
            total += 4;
            if (csb0 !== 1'b0 || web0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL init_select[%0d]: csb0=%b web0=%b, required 0/0", i, csb0, web0);
            end
            if (addr0 !== 4'(i)) begin
                bad++;
                $display("[TB] FAIL init_addr[%0d]: got %0d, required %0d", i, addr0, i);
            end
            if (din0 !== 2'd0) begin
                bad++;
                $display("[TB] FAIL init_din[%0d]: got %0d, required 0", i, din0);
            end
            if (init_done !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL init_flags[%0d]: init_done=%b req_ready=%b, required 0/0", i, init_done, req_ready);
            end
        end
        req_valid = 1'b0;
        @(negedge clk0);
        total += 3;
        if (init_done !== 1'b1) begin bad++; $display("[TB] FAIL init_done: got %b, required 1", init_done); end
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL run_ready: got %b, required 1", req_ready); end
        if (csb0 !== 1'b1)      begin bad++; $display("[TB] FAIL post_init_csb0: got %b, required 1", csb0); end
    endtask

    task automatic test_read_after_init();
        @(negedge clk0);
        applyStimulus(1'b0, 4'd5, 2'd0);
        @(negedge clk0);
        req_valid = 1'b0;
        total += 2;
        if (csb0 !== 1'b0 || web0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_pins: csb0=%b web0=%b, required 0/1", csb0, web0);
        end
        if (addr0 !== 4'd5) begin
            bad++;
            $display("[TB] FAIL read_addr: got %0d, required 5", addr0);
        end
        waitDrain("read_after_init");
    endtask

    task automatic test_write_then_read();
        @(negedge clk0);
        applyStimulus(1'b1, 4'd3, 2'b10);
        @(negedge clk0);
        total += 2;
        if (web0 !== 1'b0 || din0 !== 2'b10) begin
            bad++;
            $display("[TB] FAIL write_pins: web0=%b din0=%0d, required 0/2", web0, din0);
        end
        applyStimulus(1'b0, 4'd3, 2'd0);
        @(negedge clk0);
        req_valid = 1'b0;
        if (web0 !== 1'b1 || din0 !== 2'b10) begin
            bad++;
            $display("[TB] FAIL read_holds_din: web0=%b din0=%0d, required 1/2", web0, din0);
        end
        waitDrain("write_then_read");
    endtask

    task automatic test_back_to_back();
        logic       prevWe;
        logic [3:0] prevAddr;
        logic [1:0] prevData;
        prevWe   = 1'b0;
        prevAddr = '0;
        prevData = '0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk0);
            if (i > 0) begin
                total += 3;
                if (csb0 !== 1'b0 || web0 !== ~prevWe) begin
                    bad++;
                    $display("[TB] FAIL b2b_select[%0d]: csb0=%b web0=%b, required 0/%b", i - 1, csb0, web0, ~prevWe);
                end
                if (addr0 !== prevAddr) begin
                    bad++;
                    $display("[TB] FAIL b2b_addr[%0d]: got %0d, required %0d", i - 1, addr0, prevAddr);
                end
                if (din0 !== prevData) begin
                    bad++;
                    $display("[TB] FAIL b2b_din[%0d]: got %0d, required %0d", i - 1, din0, prevData);
                end
            end
            if (i < 32) begin
                prevWe   = (i < 16);
                prevAddr = 4'(i % 16);
                if (prevWe) prevData = 2'((i % 3) + 1);
                applyStimulus(prevWe, prevAddr, 2'((i % 3) + 1));
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk0);
        total += 2;
        if (csb0 !== 1'b1 || web0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL idle_select: csb0=%b web0=%b, required 1/1", csb0, web0);
        end
        if (addr0 !== 4'd15 || din0 !== 2'd1) begin
            bad++;
            $display("[TB] FAIL idle_hold: addr0=%0d din0=%0d, required 15/1", addr0, din0);
        end
        waitDrain("back_to_back");
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk0);
        rst0_n = 1'b0;
        clearShadow();
        @(negedge clk0);
        rst0_n = 1'b1;
        repeat (7) @(negedge clk0);
        total++;
        if (addr0 !== 4'd6) begin
            bad++;
            $display("[TB] FAIL mid_init_progress: addr0=%0d, required 6", addr0);
        end
        rst0_n = 1'b0;
        #1;
        total += 2;
        if (csb0 !== 1'b1 || web0 !== 1'b1 || addr0 !== 4'd0) begin
            bad++;
            $display("[TB] FAIL mid_init_idle: csb0=%b web0=%b addr0=%0d, required 1/1/0", csb0, web0, addr0);
        end
        if (init_done !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_init_flags: init_done=%b req_ready=%b, required 0/0", init_done, req_ready);
        end
        @(negedge clk0);
        test_init_sweep();
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk0);
        applyStimulus(1'b1, 4'd9, 2'b11);
        @(negedge clk0);
        applyStimulus(1'b0, 4'd9, 2'd0);
        @(negedge clk0);
        applyStimulus(1'b0, 4'd9, 2'd0);
        @(negedge clk0);
        req_valid = 1'b0;
        rst0_n    = 1'b0;
        expQ.delete();
        accQ.delete();
        clearShadow();
        #1;
        total++;
        if (rsp_valid !== 1'b0 || csb0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_run_idle: rsp_valid=%b csb0=%b, required 0/1", rsp_valid, csb0);
        end
        repeat (3) @(negedge clk0);
        test_init_sweep();
        @(negedge clk0);
        applyStimulus(1'b0, 4'd9, 2'd0);
        @(negedge clk0);
        req_valid = 1'b0;
        waitDrain("reset_mid_run");
    endtask

    initial begin
        rst0_n    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        clearShadow();
        test_reset();
        test_init_sweep();
        test_read_after_init();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid_init();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
